// File: rtl/dmx_write_arbiter_if.sv
// rtl/dmx_write_arbiter_if.sv - requester and transmitter-side signals of dmx_write_arbiter
// Optional blackout signal exists only when DMX_ARB_BLACKOUT_EN is defined.
interface dmx_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*10-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ*3-1:0]  req_size;
  logic [NUM_REQ-1:0]    gnt;
`ifdef DMX_ARB_BLACKOUT_EN
  logic                  blackout;
`endif
  logic                  busy;
  logic [9:0]            write_addr;
  logic [7:0]            write_data0;
  logic [7:0]            write_data1;
  logic [7:0]            write_data2;
  logic [7:0]            write_data3;
  logic [2:0]            write_size;
  logic                  write_en;

  modport slave (
`ifdef DMX_ARB_BLACKOUT_EN
    input  blackout,
`endif
    input  req, req_addr, req_data, req_size,
    output gnt, busy, write_addr, write_data0, write_data1, write_data2, write_data3,
           write_size, write_en
  );

  modport master (
`ifdef DMX_ARB_BLACKOUT_EN
    output blackout,
`endif
    output req, req_addr, req_data, req_size,
    input  gnt, busy, write_addr, write_data0, write_data1, write_data2, write_data3,
           write_size, write_en
  );
endinterface

// File: rtl/dmx_write_arbiter.sv
// rtl/dmx_write_arbiter.sv - round-robin arbiter for the DMX512 transmitter write port
// Define DMX_ARB_BLACKOUT_EN to add the self-timed 512-channel blackout sweep.
module dmx_write_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmx_write_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   last_q;
  logic [9:0]         addr_q;
  logic [31:0]        data_q;
  logic [2:0]         size_q;
  logic               en_q;

  logic [NUM_REQ-1:0] gnt_d;
  logic               gnt_any_d;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic [IDX_W-1:0]   idx_d;
  logic [9:0]         addr_d;
  logic [31:0]        data_d;
  logic [2:0]         raw_size_d;
  logic [2:0]         size_d;
  logic               arb_en;

`ifdef DMX_ARB_BLACKOUT_EN
  typedef enum logic [1:0] {ARB, SWEEP, HOLD} state_t;
  state_t     state_q;
  logic [6:0] cnt_q;

  assign arb_en   = (state_q == ARB);
  assign bus.busy = (state_q != ARB);
`else
  assign arb_en   = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // Rotating search from last+1; grant never looks at the payload.
  always_comb begin
    gnt_d      = '0;
    gnt_any_d  = 1'b0;
    gnt_idx_d  = '0;
    idx_d      = '0;
    addr_d     = '0;
    data_d     = '0;
    raw_size_d = '0;
    if (!rst && arb_en) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        idx_d = IDX_W'((int'(last_q) + off) % NUM_REQ);
        if (!gnt_any_d && bus.req[idx_d]) begin
          gnt_any_d        = 1'b1;
          gnt_idx_d        = idx_d;
          gnt_d[idx_d]     = 1'b1;
          addr_d           = bus.req_addr[idx_d*10 +: 10];
          data_d           = bus.req_data[idx_d*32 +: 32];
          raw_size_d       = bus.req_size[idx_d*3 +: 3];
        end
      end
    end
  end

  assign size_d = (raw_size_d > 3'd4) ? 3'd4 : raw_size_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      en_q    <= 1'b0;
`ifdef DMX_ARB_BLACKOUT_EN
      state_q <= ARB;
      cnt_q   <= '0;
`endif
    end else begin
      en_q <= 1'b0;
      // Zero-size grants still advance the rotation but produce no strobe.
      if (gnt_any_d) begin
        last_q <= gnt_idx_d;
        if (size_d != 3'd0) begin
          addr_q <= addr_d;
          data_q <= data_d;
          size_q <= size_d;
          en_q   <= 1'b1;
        end
      end
`ifdef DMX_ARB_BLACKOUT_EN
      case (state_q)
        ARB: begin
          if (bus.blackout) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          addr_q <= {1'b0, cnt_q, 2'b01};
          data_q <= '0;
          size_q <= 3'd4;
          en_q   <= 1'b1;
          cnt_q  <= cnt_q + 7'd1;
          if (cnt_q == 7'd127) state_q <= bus.blackout ? HOLD : ARB;
        end
        HOLD: begin
          if (!bus.blackout) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
`endif
    end
  end

  assign bus.gnt         = gnt_d;
  assign bus.write_addr  = addr_q;
  assign bus.write_data0 = data_q[7:0];
  assign bus.write_data1 = data_q[15:8];
  assign bus.write_data2 = data_q[23:16];
  assign bus.write_data3 = data_q[31:24];
  assign bus.write_size  = size_q;
  assign bus.write_en    = en_q;
endmodule

// File: tb/tb_dmx_write_arbiter.sv
// tb/tb_dmx_write_arbiter.sv - self-checking bench for dmx_write_arbiter
module tb_dmx_write_arbiter;
  logic clk;
  logic rst;

  dmx_write_arbiter_if #(.NUM_REQ(4)) bus ();

  dmx_write_arbiter #(.NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        en;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [2:0]  size;
  } exp_t;

  exp_t sb[$];
  exp_t m_out;
  int   m_last;
  int   m_state;
  int   m_cnt;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic [9:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    bus.req[i]             = r;
    bus.req_addr[10*i +: 10] = a;
    bus.req_data[32*i +: 32] = d;
    bus.req_size[3*i +: 3]   = s;
  endtask

  task automatic model_reset();
    m_last  = 3;
    m_state = 0;
    m_cnt   = 0;
    m_out   = '0;
    sb.delete();
  endtask

  // Drive is already applied; predict this cycle, clock it, compare the registered result.
  task automatic run_cycle(output logic [3:0] g);
    exp_t       e;
    int         idx;
    logic [3:0] eg;
    logic [2:0] sz;
    #1;
    eg   = '0;
    e    = m_out;
    e.en = 1'b0;
    chk("busy", bus.busy, (m_state != 0));
    if (m_state == 0) begin
      idx = -1;
      for (int off = 1; off <= 4; off++)
        if (idx < 0 && bus.req[(m_last + off) % 4]) idx = (m_last + off) % 4;
      if (idx >= 0) begin
        eg[idx] = 1'b1;
        m_last  = idx;
        sz      = bus.req_size[3*idx +: 3];
        if (sz > 3'd4) sz = 3'd4;
        if (sz != 3'd0) begin
          e.en   = 1'b1;
          e.addr = bus.req_addr[10*idx +: 10];
          e.data = bus.req_data[32*idx +: 32];
          e.size = sz;
        end
      end
`ifdef DMX_ARB_BLACKOUT_EN
      if (bus.blackout) begin
        m_state = 1;
        m_cnt   = 0;
      end
    end else if (m_state == 1) begin
      e.en   = 1'b1;
      e.addr = 10'(1 + 4 * m_cnt);
      e.data = '0;
      e.size = 3'd4;
      if (m_cnt == 127) m_state = bus.blackout ? 2 : 0;
      m_cnt++;
    end else begin
      if (!bus.blackout) m_state = 0;
`endif
    end
    chk("gnt", bus.gnt, eg);
    g = bus.gnt;
    if (e.en) m_out = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("write_en", bus.write_en, e.en);
    chk("write_addr", bus.write_addr, e.addr);
    chk("write_data0", bus.write_data0, e.data[7:0]);
    chk("write_data1", bus.write_data1, e.data[15:8]);
    chk("write_data2", bus.write_data2, e.data[23:16]);
    chk("write_data3", bus.write_data3, e.data[31:24]);
    chk("write_size", bus.write_size, e.size);
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] one;
    logic [3:0] prev_g;
    logic       r2;
    int         r2_wait;
    int         cool;
    logic [7:0] b0;
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_size = '0;
`ifdef DMX_ARB_BLACKOUT_EN
    bus.blackout = 1'b0;
`endif

    // Reset values; gnt must stay low even with every request raised.
    @(posedge clk);
    #1;
    bus.req = 4'b1111;
    #1;
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_write_en", bus.write_en, 1'b0);
    chk("rst_write_addr", bus.write_addr, 10'd0);
    chk("rst_write_data", {bus.write_data3, bus.write_data2, bus.write_data1, bus.write_data0}, 32'd0);
    chk("rst_write_size", bus.write_size, 3'd0);
    chk("rst_busy", bus.busy, 1'b0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All four requesting: strict rotation starting at requester 0.
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 10'(100 + 4*i), {8'hD0, 8'hC0, 8'hB0, 8'(8'hA1 + i)}, 3'd4);
    for (int k = 0; k < 8; k++) begin
      run_cycle(g);
      one = 4'b0001 << (k % 4);
      chk("rr_order", g, one);
    end

    // Idle: outputs hold.
    bus.req = '0;
    repeat (2) run_cycle(g);

    // Single-transfer latency.
    set_req(1, 1'b1, 10'd10, 32'h44332211, 3'd4);
    run_cycle(g);
    chk("single_gnt", g, 4'b0010);
    bus.req[1] = 1'b0;
    chk("single_addr", bus.write_addr, 10'd10);
    chk("single_d0", bus.write_data0, 8'h11);
    chk("single_d3", bus.write_data3, 8'h44);
    chk("single_size", bus.write_size, 3'd4);
    chk("single_en", bus.write_en, 1'b1);
    run_cycle(g);
    chk("single_en_drop", bus.write_en, 1'b0);

    // Size 0 consumed without strobe; rotation moves past it.
    set_req(2, 1'b1, 10'd20, 32'h01010101, 3'd0);
    run_cycle(g);
    chk("size0_gnt", g, 4'b0100);
    chk("size0_no_en", bus.write_en, 1'b0);
    set_req(2, 1'b1, 10'd21, 32'h02020202, 3'd4);
    set_req(3, 1'b1, 10'd22, 32'h03030303, 3'd4);
    run_cycle(g);
    chk("size0_next", g, 4'b1000);
    bus.req[3] = 1'b0;
    run_cycle(g);
    bus.req = '0;

    // Size 7 clamps to 4.
    set_req(0, 1'b1, 10'd30, 32'h55667788, 3'd7);
    run_cycle(g);
    chk("size7_clamp", bus.write_size, 3'd4);
    bus.req = '0;

    // Fairness: req0 held, req2 pulsing.
    set_req(0, 1'b1, 10'd40, 32'h0A0B0C0D, 3'd4);
    set_req(2, 1'b0, 10'd42, 32'h1A1B1C1D, 3'd3);
    r2 = 1'b0;
    r2_wait = 0;
    cool = 0;
    prev_g = '0;
    for (int k = 0; k < 30; k++) begin
      if (!r2 && cool == 0) begin
        r2 = 1'b1;
        r2_wait = 0;
      end
      bus.req[2] = r2;
      run_cycle(g);
      if (r2 && prev_g[0]) chk("fair_no_double", g[0], 1'b0);
      if (r2) begin
        r2_wait++;
        if (g[2]) begin
          chk("fair_latency", (r2_wait <= 2), 1'b1);
          r2 = 1'b0;
          cool = $urandom_range(0, 2);
        end
      end else if (cool > 0) begin
        cool--;
      end
      prev_g = g;
    end
    bus.req = '0;

    // Random request masks and payloads.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        b0 = 8'($urandom) | 8'h01;
        set_req(i, 1'($urandom), 10'($urandom), {24'($urandom), b0}, 3'($urandom));
      end
      run_cycle(g);
    end
    bus.req = '0;

`ifdef DMX_ARB_BLACKOUT_EN
    begin
      logic [3:0] g_pre;
      logic [3:0] g_post;
      int         nsw;
      int         nen;
      int         first_a;
      int         last_a;
      for (int i = 0; i < 4; i++)
        set_req(i, 1'b1, 10'(200 + i), {8'hEE, 8'hEE, 8'hEE, 8'(8'h31 + i)}, 3'd4);
      run_cycle(g);
      // One-cycle blackout pulse while all requesters are active.
      bus.blackout = 1'b1;
      run_cycle(g_pre);
      bus.blackout = 1'b0;
      nsw = 0;
      first_a = -1;
      last_a = -1;
      g_post = '0;
      for (int k = 0; k < 140; k++) begin
        run_cycle(g);
        if (bus.write_en && bus.write_data0 == 8'd0 && bus.write_size == 3'd4) begin
          nsw++;
          if (first_a < 0) first_a = int'(bus.write_addr);
          last_a = int'(bus.write_addr);
        end
        if (g_post == 4'b0000 && g != 4'b0000) g_post = g;
      end
      chk("sweep_writes", nsw, 128);
      chk("sweep_first_addr", first_a, 1);
      chk("sweep_last_addr", last_a, 509);
      chk("sweep_resume", g_post, {g_pre[2:0], g_pre[3]});

      // Blackout held 200 cycles: one requester write, 128 sweep writes, then hold.
      bus.blackout = 1'b1;
      nen = 0;
      for (int k = 0; k < 200; k++) begin
        run_cycle(g);
        if (bus.write_en) nen++;
      end
      chk("hold_write_count", nen, 129);
      chk("hold_busy", bus.busy, 1'b1);
      bus.blackout = 1'b0;
      run_cycle(g);
      chk("hold_last_gnt", g, 4'b0000);
      run_cycle(g);
      chk("hold_exit_gnt", (g != 4'b0000), 1'b1);

      // Reset mid-sweep.
      bus.blackout = 1'b1;
      run_cycle(g);
      bus.blackout = 1'b0;
      repeat (20) run_cycle(g);
      rst = 1'b1;
      #1;
      chk("midrst_write_en", bus.write_en, 1'b0);
      chk("midrst_write_addr", bus.write_addr, 10'd0);
      chk("midrst_write_size", bus.write_size, 3'd0);
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_gnt", bus.gnt, 4'b0000);
      bus.req = '0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.req = 4'b1111;
      run_cycle(g);
      chk("midrst_first_gnt", g, 4'b0001);
      repeat (3) run_cycle(g);
      bus.req = '0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmx_write_arbiter.md
# dmx_write_arbiter

Round-robin arbiter that shares the single write port of the DMX512 universe transmitter among up to `NUM_REQ` requesters, e.g. host bus bridge, fade engine and scene sequencer. It sits directly in front of the transmitter and drives that block's `write_addr`, `write_data0..3`, `write_size` and `write_en` inputs from registers. Optionally it runs a self-timed blackout sweep that zeroes all 512 channels with priority over every requester.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `req`  in  NUM_REQ: per-requester request; held with payload until granted.
- `req_addr`  in  NUM_REQ*10: first channel address per requester; slice i = [10i+9:10i].
- `req_data`  in  NUM_REQ*32: four data bytes per requester; byte k of requester i = [32i+8k+7:32i+8k].
- `req_size`  in  NUM_REQ*3: byte count per requester, 0..4.
- `gnt`  out  NUM_REQ: combinational one-hot grant; transfer occurs on an edge where `req[i] && gnt[i]`.
- `blackout`  in  1: blackout request. Present only with `DMX_ARB_BLACKOUT_EN`.
- `busy`  out  1: high while a blackout sweep or hold is active.
- `write_addr`  out  10: registered start address to the transmitter.
- `write_data0..3`  out  8 each: registered data bytes.
- `write_size`  out  3: registered byte count, 1..4.
- `write_en`  out  1: registered write strobe, one cycle per accepted transfer.

## Operation
- **States**
  - ARB: normal arbitration.
  - SWEEP: blackout writes in progress.
  - HOLD: sweep done, blackout still high.
- **ARB state**
  - Search starts at `(last + 1) mod NUM_REQ` and wraps. The first index with `req` high gets `gnt`.
  - At most one grant per cycle. `gnt` depends only on `req`, `last` and the state, never on the payload.
- **On an accepting edge**
  - `last` takes the granted index.
  - The payload is captured into the output registers.
  - `write_en` is high for exactly the following cycle.
- **Size handling**
  - `req_size` > 4 is clamped to 4.
  - `req_size` == 0 is granted and consumed: `last` updates, but `write_en` stays 0.
- **Address handling**
  - Addresses are forwarded unchanged, with no range check.
  - Bytes mapping to channel 0 or above 512 are discarded by the transmitter.
- **No request:** when no `req` is high, `write_en` is 0 and the output data registers hold their last value.
- **Back-to-back:** a requester holding `req` high is granted again only after every other active requester has had one grant. This is strict round-robin fairness.

## Timing
- **Reset values**
  - `gnt` = 0, `write_en` = 0, `write_addr` = 0, `write_data0..3` = 0, `write_size` = 0, `busy` = 0.
  - State = ARB.
  - `last` = NUM_REQ-1, so requester 0 wins the first cycle.
- **Latency:** `req` high in cycle N with `gnt` high in cycle N gives `write_en` high in cycle N+1.
- **Throughput:** sustained one write per cycle, 4 channels per write.
- **Payload stability:** payload only needs to be valid in the granted cycle. Requesters may change payload freely while ungranted.
- **Reset mid-transfer:** a captured but not yet strobed write is lost. `write_en` stays 0 while `rst` is high.
- **Simultaneous requests:** all N requesters requesting in the same cycle are served in N consecutive cycles, in rotating order.

## Configuration
- **`DMX_ARB_BLACKOUT_EN` defined**
  - `blackout` port exists. It is sampled only in ARB state.
  - `blackout` high enters SWEEP on the next edge. `gnt` is forced to 0 from that cycle.
  - SWEEP issues 128 consecutive writes: addr 1, 5, 9, …, 509; size 4; data 0. `write_en` stays high continuously for 128 cycles.
  - An internal 7-bit counter tracks the sweep. `blackout` toggling during SWEEP is ignored.
  - After the write to addr 509:
    - `blackout` still high: go to HOLD. `gnt` = 0 and no writes until `blackout` falls, then return to ARB.
    - `blackout` low: return to ARB directly.
  - `busy` is high in SWEEP and HOLD. `last` is unchanged by a sweep.
  - A requester granted in the cycle `blackout` is sampled still completes. Its `write_en` precedes the first sweep write.
- **`DMX_ARB_BLACKOUT_EN` undefined**
  - No `blackout` port and no SWEEP/HOLD logic.
  - `busy` is tied 0. The arbiter is permanently in ARB.

## Test plan
- **Post-reset first grant:** after reset, `req` = 4'b1111 held high gives grants in order 0,1,2,3,0,… one per cycle. `write_en` is continuously high from the cycle after the first grant.
- **Single-transfer latency:** req1 alone with addr 10, data {0x11,0x22,0x33,0x44}, size 4, granted in cycle N. In cycle N+1 expect `write_addr` = 10, `write_data0..3` = 0x11/0x22/0x33/0x44, `write_size` = 4, `write_en` = 1. In cycle N+2 expect `write_en` = 0.
- **Size edge cases:** size 0 produces `gnt` with no `write_en`; the next arbitration starts after that index. Size 7 produces `write_size` = 4.
- **Fairness with two requesters:** req0 held continuously and req2 pulsing gives req2 a grant within at most 2 cycles of asserting `req`. req0 is never granted twice in a row while req2 is pending.
- **Blackout sweep (macro defined):** `blackout` pulsed for 1 cycle while requesters are active gives exactly 128 writes, addr 1..509 step 4, all data 0, `gnt` = 0 throughout and `busy` high. Arbitration then resumes from the pre-sweep `last`.
- **Blackout hold and reset (macro defined):** `blackout` held 200 cycles gives a 128-cycle SWEEP, then HOLD with no writes, then ARB one cycle after `blackout` falls. `rst` asserted mid-sweep drops all outputs to 0 immediately, and after reset release the state is ARB.
